aes_key_sched_rev: RTL and testbench

Sequential AES-128 round-key generator for the decryption datapath. It accepts a 128-bit cipher key and walks the key schedule forward one round per cycle to reach round key 10. It then walks the schedule backward with the inverse recurrence, emitting round keys 10 down to 0 over a valid/ready stream. It sits between key load and the AES decrypt round engine, which consumes round keys in reverse order, and it replaces a 1408-bit fully-expanded key array.

---
 rtl/aes_pkg.sv | 64 ++++++
 rtl/aes_subword.sv | 19 +
 rtl/aes_key_sched_rev.sv | 133 +++++++++++++
 tb/tb_aes_key_sched_rev.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// aes_pkg
//   Shared AES-128 key-schedule definitions. It holds the key-scheduler state
//   enum, the S-box lookup, Rcon, RotWord and the round-key width constants.
//   Words are 32 bits. Byte 0 of a word sits in bits [31:24].
package aes_pkg;

  localparam int ROUND_KEY_W = 128;
  localparam int LAST_ROUND  = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    EMIT = 2'd2
  } state_t;

  // Forward S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[2047 - 8*int'(b) -: 8];
  endfunction

  // Round constant in the top byte. Index 0 or anything above 10 yields 0.
  function automatic logic [31:0] rcon(input logic [3:0] round);
    logic [7:0] rc;
    case (round)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return {rc, 24'h000000};
  endfunction

  // Cyclic left rotation by one byte: [a0,a1,a2,a3] -> [a1,a2,a3,a0].
  function automatic logic [31:0] rotword(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_subword.sv
// aes_subword
//   Combinational SubWord. It applies four parallel S-box lookups, one per byte
//   of a 32-bit word. The block is shared by the forward and inverse key steps
//   and is usable by the encrypt datapath as well.
//   Ports:
//     word_in   in  [31:0]  word to substitute
//     word_out  out [31:0]  byte-wise S-box of word_in
module aes_subword
  import aes_pkg::*;
(
  input  logic [31:0] word_in,
  output logic [31:0] word_out
);

  for (genvar gi = 0; gi < 4; gi++) begin : g_byte
    assign word_out[8*gi +: 8] = sbox(word_in[8*gi +: 8]);
  end

endmodule

// File: rtl/aes_key_sched_rev.sv
// aes_key_sched_rev
//   Sequential AES-128 round-key generator for decryption. After start, the
//   block walks the key schedule forward one round per cycle until it reaches
//   round key 10. It then emits round keys 10 down to 0 over a valid/ready
//   stream, and recovers each previous key with the inverse recurrence.
//   Ports:
//     clk       in   1        rising-edge clock
//     rst       in   1        synchronous active-high reset
//     start     in   1        begin a schedule; sampled only while idle
//     key_in    in   [0:127]  cipher key, word 0 = bits [0:31]
//     busy      out  1        schedule in progress (forward walk or emit)
//     rk_valid  out  1        rk_out/rk_round hold a round key
//     rk_ready  in   1        consumer accepts on rk_valid && rk_ready
//     rk_out    out  [0:127]  round key, same bit order as key_in
//     rk_round  out  4        round index of rk_out, 10 down to 0
//     done      out  1        one-cycle pulse after round key 0 is accepted
module aes_key_sched_rev
  import aes_pkg::*;
#(
  parameter int NK = 4,
  parameter int NR = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [0:ROUND_KEY_W-1] key_in,
  output logic                   busy,
  output logic                   rk_valid,
  input  logic                   rk_ready,
  output logic [0:ROUND_KEY_W-1] rk_out,
  output logic [3:0]             rk_round,
  output logic                   done
);

  if (NK != 4 || NR != LAST_ROUND) begin : g_bad_params
    $error("aes_key_sched_rev supports only NK=4, NR=10");
  end

  state_t                   state_reg;
  logic [0:ROUND_KEY_W-1]   kreg_reg;
  logic [3:0]               round_reg;
  logic                     busy_reg;
  logic                     rk_valid_reg;
  logic                     done_reg;

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] n0, n1, n2, n3;
  logic [31:0] p0, p1, p2, p3;
  logic [31:0] sub_in, sub_out, t_fwd;

  assign w0 = kreg_reg[0:31];
  assign w1 = kreg_reg[32:63];
  assign w2 = kreg_reg[64:95];
  assign w3 = kreg_reg[96:127];

  // Inverse step. The last word of the previous round key is recovered first,
  // because it feeds the shared SubWord path that rebuilds word 0.
  assign p3 = w3 ^ w2;
  assign p2 = w2 ^ w1;
  assign p1 = w1 ^ w0;

  // One SubWord instance serves both directions. It takes w3 while walking
  // forward and p3 while emitting.
  assign sub_in = (state_reg == EMIT) ? rotword(p3) : rotword(w3);

  aes_subword u_subword (
    .word_in  (sub_in),
    .word_out (sub_out)
  );

  assign t_fwd = sub_out ^ rcon(round_reg + 4'd1);
  assign n0    = w0 ^ t_fwd;
  assign n1    = w1 ^ n0;
  assign n2    = w2 ^ n1;
  assign n3    = w3 ^ n2;

  // Key round_reg was produced using Rcon(round_reg), so undo with the same one.
  assign p0    = w0 ^ sub_out ^ rcon(round_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      kreg_reg     <= '0;
      round_reg    <= 4'd0;
      busy_reg     <= 1'b0;
      rk_valid_reg <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            kreg_reg  <= key_in;
            round_reg <= 4'd0;
            busy_reg  <= 1'b1;
            state_reg <= FWD;
          end
        end
        FWD: begin
          kreg_reg  <= {n0, n1, n2, n3};
          round_reg <= round_reg + 4'd1;
          if (round_reg == 4'(LAST_ROUND - 1)) begin
            state_reg    <= EMIT;
            rk_valid_reg <= 1'b1;
          end
        end
        EMIT: begin
          if (rk_ready) begin
            if (round_reg != 4'd0) begin
              kreg_reg  <= {p0, p1, p2, p3};
              round_reg <= round_reg - 4'd1;
            end else begin
              state_reg    <= IDLE;
              busy_reg     <= 1'b0;
              rk_valid_reg <= 1'b0;
              done_reg     <= 1'b1;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_reg;
  assign rk_valid = rk_valid_reg;
  assign rk_out   = kreg_reg;
  assign rk_round = round_reg;
  assign done     = done_reg;

endmodule

// File: tb/tb_aes_key_sched_rev.sv
// tb_aes_key_sched_rev
//   Directed sequence with random keys and random backpressure. The reference
//   key schedule uses the FIPS-197 forward word expansion over all 44 words.
//   Its S-box is derived from GF(2^8) inversion plus the affine map.
module tb_aes_key_sched_rev;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [0:127] key_in;
  logic         busy;
  logic         rk_valid;
  logic         rk_ready;
  logic [0:127] rk_out;
  logic [3:0]   rk_round;
  logic         done;

  int checks = 0;
  int errors = 0;

  logic [7:0]   sb     [256];
  logic [127:0] exp_rk [11];
  logic [127:0] got_rk [11];

  always #5 clk = ~clk;

  aes_key_sched_rev dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .key_in   (key_in),
    .busy     (busy),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk_out   (rk_out),
    .rk_round (rk_round),
    .done     (done)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // Forward FIPS-197 expansion of all 44 words, then grouped into round keys.
  task automatic expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] temp;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      temp = w[i-1];
      if (i % 4 == 0) begin
        temp = {temp[23:0], temp[31:24]};
        temp = {sb[temp[31:24]], sb[temp[23:16]], sb[temp[15:8]], sb[temp[7:0]]} ^ {rc, 24'h0};
        rc   = gf_mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ temp;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Runs one key set. The task starts at 1 time unit after a clock edge.
  // Setting abort_round >= 0 stalls at that round and then applies reset.
  task automatic run_key(input logic [127:0] key, input int ready_pct,
                         input bit poke_fwd, input bit poke_emit, input int abort_round);
    int r;
    bit finished;
    bit aborted;
    bit rdy;
    expand(key);
    key_in   = key;
    start    = 1'b1;
    rk_ready = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    key_in = ~key;  // must not matter once accepted
    chk("busy_after_start", 128'(busy), 128'(1'b1));
    chk("done_low_after_start", 128'(done), 128'(1'b0));
    chk("valid_low_after_start", 128'(rk_valid), 128'(1'b0));
    for (int c = 1; c <= 9; c++) begin
      if (poke_fwd && c == 3) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("fwd_valid_low", 128'(rk_valid), 128'(1'b0));
    end
    @(posedge clk); #1;
    r = 10;
    finished = 1'b0;
    aborted  = 1'b0;
    for (int cyc = 0; cyc < 500 && !finished; cyc++) begin
      chk("emit_valid", 128'(rk_valid), 128'(1'b1));
      chk("emit_round", 128'(rk_round), 128'(r));
      chk("emit_key", 128'(rk_out), exp_rk[r]);
      chk("emit_done_low", 128'(done), 128'(1'b0));
      got_rk[r] = rk_out;
      if (abort_round >= 0 && r == abort_round) begin
        rk_ready = 1'b0;
        repeat (2) begin
          @(posedge clk); #1;
          chk("stall_round", 128'(rk_round), 128'(r));
          chk("stall_key", 128'(rk_out), exp_rk[r]);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_busy", 128'(busy), 128'(1'b0));
        chk("rst_valid", 128'(rk_valid), 128'(1'b0));
        chk("rst_key", 128'(rk_out), 128'(0));
        chk("rst_round", 128'(rk_round), 128'(0));
        chk("rst_done", 128'(done), 128'(1'b0));
        aborted  = 1'b1;
        finished = 1'b1;
      end else begin
        rdy      = ($urandom_range(0, 99) < ready_pct);
        rk_ready = rdy;
        if (poke_emit && cyc == 2) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (rdy) begin
          if (r == 0) finished = 1'b1;
          else r--;
        end
      end
    end
    chk("emit_timeout", 128'(finished), 128'(1'b1));
    if (finished && !aborted) begin
      chk("done_pulse", 128'(done), 128'(1'b1));
      chk("done_busy_low", 128'(busy), 128'(1'b0));
      chk("done_valid_low", 128'(rk_valid), 128'(1'b0));
    end
    $display("key %h ready%%=%0d aborted=%0d checks=%0d errors=%0d", key, ready_pct, aborted, checks, errors);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] k;
    rst      = 1'b1;
    start    = 1'b0;
    rk_ready = 1'b0;
    key_in   = '0;
    build_sbox();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 128'(busy), 128'(1'b0));
    chk("reset_valid", 128'(rk_valid), 128'(1'b0));
    chk("reset_key", 128'(rk_out), 128'(0));
    chk("reset_round", 128'(rk_round), 128'(0));
    chk("reset_done", 128'(done), 128'(1'b0));
    rst = 1'b0;
    @(posedge clk); #1;

    // Key from the FIPS-197 example with no backpressure. Start is poked during the forward walk.
    k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    run_key(k, 100, 1'b1, 1'b0, -1);
    chk("k1_round10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("k1_round1", got_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
    chk("k1_round0", got_rk[0], k);

    // Started in the done cycle. Start is poked while emitting.
    k = 128'h000102030405060708090a0b0c0d0e0f;
    run_key(k, 100, 1'b0, 1'b1, -1);
    chk("k2_round10", got_rk[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);

    // Random keys with roughly 30% stall cycles.
    for (int i = 0; i < 3; i++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      run_key(k, 70, 1'b1, 1'b1, -1);
      chk("rand_round0", got_rk[0], k);
    end

    // All-ones key under backpressure.
    k = '1;
    run_key(k, 70, 1'b0, 1'b0, -1);
    chk("ones_round0", got_rk[0], k);

    // Reset while round 5 is stalled, then a fresh schedule.
    k = {$urandom, $urandom, $urandom, $urandom};
    run_key(k, 100, 1'b0, 1'b0, 5);
    k = {$urandom, $urandom, $urandom, $urandom};
    run_key(k, 80, 1'b0, 1'b0, -1);
    chk("after_rst_round0", got_rk[0], k);

    @(posedge clk); #1;
    chk("idle_done_low", 128'(done), 128'(1'b0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
